// File: rtl/regfile_scoreboard.sv
// Architectural register file with combinational writeback bypass on two read
// ports and a per-register pending scoreboard for RAW/WAW hazard detection.
module regfile_scoreboard #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int R0_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_write_enable,
  input  logic [ADDR_W-1:0]   wb_reg_addr,
  input  logic [DATA_W-1:0]   wb_write_data,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic                rd_ready_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_ready_b,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                issue_stall,
  output logic                issue_accept,
  input  logic                flush,
  output logic [ADDR_W:0]     pending_count
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam bit HAS_R0   = (R0_ZERO != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  logic wb_commit;
  logic wb_clr_dest;
  logic issue_sets;

  assign wb_commit = wb_write_enable && !(HAS_R0 && (wb_reg_addr == '0));

  // Issue handshake: issue_valid is a request held by decode; issue_accept is
  // asserted in the same cycle when it is taken (no flush, no WAW hazard), and
  // the destination becomes pending at that rising edge. issue_stall means the
  // request must be held and retried.
  always_comb begin
    wb_clr_dest  = wb_write_enable && (wb_reg_addr == issue_dest);
    issue_stall  = issue_valid && !flush && pending_q[issue_dest] && !wb_clr_dest;
    issue_accept = issue_valid && !flush && !issue_stall;
    issue_sets   = issue_accept && !(HAS_R0 && (issue_dest == '0));
  end

  // Lowest priority first so later assignments win: writeback, issue, flush.
  always_comb begin
    pending_d = pending_q;
    if (wb_commit) pending_d[wb_reg_addr] = 1'b0;
    if (issue_sets) pending_d[issue_dest] = 1'b1;
    if (flush) pending_d = '0;
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_commit) regs_d[wb_reg_addr] = wb_write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rd_data_a  = regs_q[rd_addr_a];
    rd_ready_a = !pending_q[rd_addr_a];
    if (HAS_R0 && (rd_addr_a == '0)) begin
      rd_data_a  = '0;
      rd_ready_a = 1'b1;
    end else if (wb_write_enable && (wb_reg_addr == rd_addr_a)) begin
      rd_data_a  = wb_write_data;
      rd_ready_a = 1'b1;
    end
  end

  always_comb begin
    rd_data_b  = regs_q[rd_addr_b];
    rd_ready_b = !pending_q[rd_addr_b];
    if (HAS_R0 && (rd_addr_b == '0)) begin
      rd_data_b  = '0;
      rd_ready_b = 1'b1;
    end else if (wb_write_enable && (wb_reg_addr == rd_addr_b)) begin
      rd_data_b  = wb_write_data;
      rd_ready_b = 1'b1;
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < NUM_REGS; i++)
      pending_count = pending_count + (ADDR_W + 1)'(pending_q[i]);
  end

endmodule
